// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, pop handshake and status bundle of the buffered UART receiver
//  slave : receiver side (uart_rx, rd_en, ovr_clr in; rd_data, rx_valid, fifo_count, overrun,
//          frame_err, parity_err out)
//  master: core/driver side, directions mirrored
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 8);
  logic                          uart_rx;
  logic                          rd_en;
  logic                          ovr_clr;
  logic [7:0]                    rd_data;
  logic                          rx_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;
  logic                          frame_err;
  logic                          parity_err;
  modport slave (input uart_rx, rd_en, ovr_clr,
                 output rd_data, rx_valid, fifo_count, overrun, frame_err, parity_err);
  modport master (output uart_rx, rd_en, ovr_clr,
                  input rd_data, rx_valid, fifo_count, overrun, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 (optional even parity) UART receiver feeding a first-word-fall-through FIFO
//  clk, rst : system clock, asynchronous active-high reset
//  bus      : uart_rx_fifo_if.slave (serial in, rd_en/ovr_clr in, FIFO head/status/error pulses out)
//  Define UART_RX_PARITY_EN to receive start + 8 data + even parity + stop frames.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BRK
  } state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            par_bad_q, par_bad_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            rx_s, tick, pop, full, wr;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  assign sync_d = {sync_q[0], bus.uart_rx};
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? CW'(CPB - 1) : cnt_q - 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    par_bad_d = par_bad_q;
    bus.frame_err  = 1'b0;
    bus.parity_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = CW'(CPB / 2);
        state_d = rx_s ? IDLE : START;
      end
      START: if (tick) begin
        state_d   = rx_s ? IDLE : DATA;
        bit_d     = '0;
        par_bad_d = 1'b0;
      end
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_d = bit_q == 3'd7 ? PARITY : DATA;
`else
        state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_bad_d = ^{shift_q, rx_s};
        state_d   = STOP;
      end
`endif
      STOP: if (tick) begin
        bus.frame_err  = !rx_s;
        bus.parity_err = par_bad_q;
        push_d         = rx_s & !par_bad_q;
        state_d        = rx_s ? IDLE : BRK;
      end
      BRK: state_d = rx_s ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  assign pop  = bus.rd_en & (count_q != '0);
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign wr   = push_q & (!full | pop);
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(wr);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    overrun_d = (push_q & !wr) | (overrun_q & !bus.ovr_clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      par_bad_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      par_bad_q <= par_bad_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= shift_q;
  end
  assign bus.rx_valid   = count_q != '0;
  assign bus.rd_data    = bus.rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.fifo_count = count_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for the buffered UART receiver
module tb_uart_rx_fifo;
  localparam int CPB   = 24000000 / 115200;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q [$];
  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();
  uart_rx_fifo #(.CLK_FREQ(24000000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #21 clk = ~clk;
  always @(negedge clk) begin
    if (bus.frame_err) fe_cnt++;
    if (bus.parity_err) pe_cnt++;
  end
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input int low_extra);
    logic pbit;
    pbit = (^b) ^ par_flip;
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.uart_rx = pbit;
    repeat (CPB) @(negedge clk);
`endif
    bus.uart_rx = stop_v;
    repeat (CPB * (1 + low_extra)) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.rx_valid && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: rx_valid timeout, got %b expected 1", name, bus.rx_valid);
    end
  endtask
  task automatic pop();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask
  task automatic test_reset();
    bus.uart_rx = 1'b1; bus.rd_en = 1'b0; bus.ovr_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.rx_valid, bus.fifo_count, bus.overrun, bus.frame_err, bus.parity_err} !== '0) begin
      fails++;
      $display("FAIL reset_flags: got valid=%b count=%0d ovr=%b fe=%b pe=%b expected all 0",
               bus.rx_valid, bus.fifo_count, bus.overrun, bus.frame_err, bus.parity_err);
    end
    tests++;
    if (bus.rd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data);
    end
  endtask
  task automatic test_single();
    logic [7:0] e;
    exp_q.push_back(8'h43);
    send_frame(8'h43, 1'b1, 1'b0, 0);
    wait_valid("single_valid");
    tests++;
    if (bus.fifo_count !== 4'd1) begin
      fails++;
      $display("FAIL single_count: got %0d expected 1", bus.fifo_count);
    end
    e = exp_q.pop_front();
    tests++;
    if (bus.rd_data !== e) begin
      fails++;
      $display("FAIL single_data: got %h expected %h", bus.rd_data, e);
    end
    pop();
    tests++;
    if (bus.rx_valid !== 1'b0 || bus.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL single_empty: got valid=%b count=%0d expected 0/0", bus.rx_valid, bus.fifo_count);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] e;
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h55);
    send_frame(8'h50, 1'b1, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b0, 0);
    wait_valid("b2b_valid");
    tests++;
    if (bus.fifo_count !== 4'd2) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 2", bus.fifo_count);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.rx_valid !== 1'b1 || bus.rd_data !== e) begin
        fails++;
        $display("FAIL b2b_data%0d: got valid=%b data=%h expected 1/%h", i, bus.rx_valid, bus.rd_data, e);
      end
      pop();
    end
    tests++;
    if (bus.rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: got valid=%b expected 0", bus.rx_valid);
    end
  endtask
  task automatic test_overrun();
    logic [7:0] e;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0, 0);
    end
    tests++;
    if (bus.fifo_count !== 4'(DEPTH) || bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_full: got count=%0d ovr=%b expected %0d/1", bus.fifo_count, bus.overrun, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.rx_valid !== 1'b1 || bus.rd_data !== e) begin
        fails++;
        $display("FAIL ovr_data%0d: got valid=%b data=%h expected 1/%h", i, bus.rx_valid, bus.rd_data, e);
      end
      pop();
    end
    pop();
    tests++;
    if (bus.fifo_count !== 4'd0 || bus.overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_sticky: got count=%0d ovr=%b expected 0/1", bus.fifo_count, bus.overrun);
    end
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear: got %b expected 0", bus.overrun);
    end
  endtask
  task automatic test_break();
    int fe0;
    logic [7:0] e;
    fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 2);
    repeat (CPB) @(negedge clk);
    tests++;
    if (fe_cnt - fe0 !== 1 || bus.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL break_frame: got pulses=%0d count=%0d expected 1/0", fe_cnt - fe0, bus.fifo_count);
    end
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0, 0);
    wait_valid("break_next_valid");
    e = exp_q.pop_front();
    tests++;
    if (bus.rd_data !== e || fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL break_next: got data=%h pulses=%0d expected %h/1", bus.rd_data, fe_cnt - fe0, e);
    end
    pop();
  endtask
  task automatic test_glitch();
    int fe0, pe0;
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    bus.uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests++;
    if (bus.fifo_count !== 4'd0 || fe_cnt != fe0 || pe_cnt != pe0) begin
      fails++;
      $display("FAIL glitch: got count=%0d fe=%0d pe=%0d expected 0/0/0",
               bus.fifo_count, fe_cnt - fe0, pe_cnt - pe0);
    end
  endtask
  task automatic test_reset_mid();
    int fe0;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    wait_valid("rstmid_prefill");
    fe0 = fe_cnt;
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.uart_rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.rx_valid, bus.fifo_count, bus.overrun, bus.frame_err, bus.parity_err, bus.rd_data} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: got valid=%b count=%0d ovr=%b fe=%b pe=%b data=%h expected all 0",
               bus.rx_valid, bus.fifo_count, bus.overrun, bus.frame_err, bus.parity_err, bus.rd_data);
    end
    bus.uart_rx = 1'b1;
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    tests++;
    if (bus.fifo_count !== 4'd0 || fe_cnt != fe0) begin
      fails++;
      $display("FAIL rstmid_after: got count=%0d fe=%0d expected 0/0", bus.fifo_count, fe_cnt - fe0);
    end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    logic [7:0] e;
    exp_q.push_back(8'h43);
    send_frame(8'h43, 1'b1, 1'b0, 0);
    wait_valid("parity_ok_valid");
    e = exp_q.pop_front();
    tests++;
    if (bus.rd_data !== e) begin
      fails++;
      $display("FAIL parity_ok: got %h expected %h", bus.rd_data, e);
    end
    pop();
    pe0 = pe_cnt;
    send_frame(8'h43, 1'b1, 1'b1, 0);
    repeat (CPB) @(negedge clk);
    tests++;
    if (pe_cnt - pe0 !== 1 || bus.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL parity_bad: got pulses=%0d count=%0d expected 1/0", pe_cnt - pe0, bus.fifo_count);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
